// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU operand mux pair
package alu_pkg;

    // Operand composition modes for a load request
    typedef enum logic [1:0] {
        MODE_ZERO    = 2'd0,
        MODE_HI_BYTE = 2'd1,
        MODE_LO_BYTE = 2'd2,
        MODE_PAIR    = 2'd3
    } mode_e;

    // Per-port operand register state
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // Target operand port of a request
    localparam logic PORT_HIGH = 1'b0;
    localparam logic PORT_LOW  = 1'b1;

    // Register pair indices
    localparam int PAIR_BC = 0;
    localparam int PAIR_DE = 1;
    localparam int PAIR_HL = 2;

endpackage

// File: rtl/operand_slot.sv
// rtl/operand_slot.sv - one operand register with EMPTY/FULL state
//   clk, notReset   : clock, async active-low reset
//   load, load_data : accepted load request and composed operand
//   take            : effective ALU consume (both operands valid)
//   operand, valid  : held operand and FULL flag
module operand_slot
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  notReset,
    input  logic                  load,
    input  logic                  take,
    input  logic [2*DATA_W-1:0]   load_data,
    output logic [2*DATA_W-1:0]   operand,
    output logic                  valid
);

    slot_state_e state;

    // A load in the same cycle as a take wins, so the slot stays FULL
    // with fresh data and the ALU sees no bubble. The operand register
    // is deliberately left untouched on take.
    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            state   <= SLOT_EMPTY;
            operand <= '0;
        end else begin
            if (load) begin
                state   <= SLOT_FULL;
                operand <= load_data;
            end else if (take && state == SLOT_FULL) begin
                state   <= SLOT_EMPTY;
            end
        end
    end

    assign valid = (state == SLOT_FULL);

endmodule

// File: rtl/alu_operand_mux_pair.sv
// rtl/alu_operand_mux_pair.sv - registered High/Low ALU operand select from register pairs
//   notHiReg, notLoReg : active-low register pairs, pair p at [p*DATA_W +: DATA_W]
//   req_*              : valid/ready load request (port, pair, mode)
//   take               : ALU consumes both operands
//   High, Low          : true-polarity operands, *_valid when held
//   sel_err            : one-cycle pulse after an accepted out-of-range pair
module alu_operand_mux_pair
    import alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NPAIR  = 3,
    parameter int SEL_W  = (NPAIR > 1) ? $clog2(NPAIR) : 1
) (
    input  logic                    clk,
    input  logic                    notReset,
    input  logic [NPAIR*DATA_W-1:0] notHiReg,
    input  logic [NPAIR*DATA_W-1:0] notLoReg,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_port,
    input  logic [SEL_W-1:0]        req_pair,
    input  logic [1:0]              req_mode,
    input  logic                    take,
    output logic [2*DATA_W-1:0]     High,
    output logic [2*DATA_W-1:0]     Low,
    output logic                    High_valid,
    output logic                    Low_valid,
    output logic                    sel_err
);

    logic                  take_eff;
    logic                  target_empty;
    logic                  accept;
    logic                  pair_hit;
    logic [DATA_W-1:0]     hi_true;
    logic [DATA_W-1:0]     lo_true;
    logic [2*DATA_W-1:0]   load_data;

    // take only counts when the ALU actually has both operands
    assign take_eff     = take && High_valid && Low_valid;
    assign target_empty = (req_port == PORT_LOW) ? !Low_valid : !High_valid;
    assign req_ready    = target_empty || take_eff;
    assign accept       = req_valid && req_ready;

    // Pair select with inversion; an index with no matching pair leaves
    // both bytes at zero, which makes every mode compose to zero.
    always_comb begin
        hi_true  = '0;
        lo_true  = '0;
        pair_hit = 1'b0;
        for (int p = 0; p < NPAIR; p++) begin
            if (req_pair == SEL_W'(p)) begin
                hi_true  = ~notHiReg[p*DATA_W +: DATA_W];
                lo_true  = ~notLoReg[p*DATA_W +: DATA_W];
                pair_hit = 1'b1;
            end
        end
    end

    always_comb begin
        load_data = '0;
        case (mode_e'(req_mode))
            MODE_ZERO:    load_data = '0;
            MODE_HI_BYTE: load_data = {{DATA_W{1'b0}}, hi_true};
            MODE_LO_BYTE: load_data = {{DATA_W{1'b0}}, lo_true};
            MODE_PAIR:    load_data = {hi_true, lo_true};
            default:      load_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge notReset) begin
        if (!notReset) begin
            sel_err <= 1'b0;
        end else begin
            sel_err <= accept && !pair_hit;
        end
    end

    operand_slot #(.DATA_W(DATA_W)) u_high_slot (
        .clk       (clk),
        .notReset  (notReset),
        .load      (accept && req_port == PORT_HIGH),
        .take      (take_eff),
        .load_data (load_data),
        .operand   (High),
        .valid     (High_valid)
    );

    operand_slot #(.DATA_W(DATA_W)) u_low_slot (
        .clk       (clk),
        .notReset  (notReset),
        .load      (accept && req_port == PORT_LOW),
        .take      (take_eff),
        .load_data (load_data),
        .operand   (Low),
        .valid     (Low_valid)
    );

endmodule

// File: tb/tb_alu_operand_mux_pair.sv
// tb/tb_alu_operand_mux_pair.sv - self-checking bench for alu_operand_mux_pair
module tb_alu_operand_mux_pair;
    import alu_pkg::*;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        notReset;
    logic [23:0] notHiReg, notLoReg;
    logic        req_valid, req_port, take;
    logic [1:0]  req_pair, req_mode;
    logic        req_ready, High_valid, Low_valid, sel_err;
    logic [15:0] High, Low;

    logic        req_valid16;
    logic [47:0] notHi16, notLo16;
    logic        req_ready16, hv16, lv16, err16;
    logic [31:0] High16, Low16;

    int checks = 0;
    int failures = 0;

    logic [15:0] m_high, m_low;
    logic        m_hv, m_lv, m_err;

    alu_operand_mux_pair u_dut (
        .clk(clk), .notReset(notReset), .notHiReg(notHiReg), .notLoReg(notLoReg),
        .req_valid(req_valid), .req_ready(req_ready), .req_port(req_port),
        .req_pair(req_pair), .req_mode(req_mode), .take(take),
        .High(High), .Low(Low), .High_valid(High_valid), .Low_valid(Low_valid),
        .sel_err(sel_err)
    );

    alu_operand_mux_pair #(.DATA_W(16)) u_dut16 (
        .clk(clk), .notReset(notReset), .notHiReg(notHi16), .notLoReg(notLo16),
        .req_valid(req_valid16), .req_ready(req_ready16), .req_port(req_port),
        .req_pair(req_pair), .req_mode(req_mode), .take(take),
        .High(High16), .Low(Low16), .High_valid(hv16), .Low_valid(lv16),
        .sel_err(err16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Operand value from the mode table: hi/lo are the inverted bytes of the pair
    function automatic logic [15:0] ref_val(input logic [23:0] nh, input logic [23:0] nl,
                                            input int pair, input int mode);
        int hi, lo;
        if (pair >= 3) return 16'h0;
        hi = 255 - ((nh >> (8 * pair)) & 255);
        lo = 255 - ((nl >> (8 * pair)) & 255);
        case (mode)
            1:       return 16'(hi);
            2:       return 16'(lo);
            3:       return 16'(hi * 256 + lo);
            default: return 16'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_high = 16'h0; m_low = 16'h0; m_hv = 1'b0; m_lv = 1'b0; m_err = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".High"},       32'(High),       32'(m_high));
        check({tag, ".Low"},        32'(Low),        32'(m_low));
        check({tag, ".High_valid"}, 32'(High_valid), 32'(m_hv));
        check({tag, ".Low_valid"},  32'(Low_valid),  32'(m_lv));
        check({tag, ".sel_err"},    32'(sel_err),    32'(m_err));
    endtask

    task automatic step(input string tag, input logic v, input logic port,
                        input int pair, input int mode, input logic tk);
        logic        tk_eff, exp_ready, acc;
        logic [15:0] val;
        @(negedge clk);
        req_valid = v; req_port = port; req_pair = 2'(pair); req_mode = 2'(mode); take = tk;
        #1;
        tk_eff    = tk && m_hv && m_lv;
        exp_ready = (port == PORT_LOW ? !m_lv : !m_hv) || tk_eff;
        check({tag, ".req_ready"}, 32'(req_ready), 32'(exp_ready));
        acc = v && exp_ready;
        val = ref_val(notHiReg, notLoReg, pair, mode);
        @(posedge clk);
        if (tk_eff) begin m_hv = 1'b0; m_lv = 1'b0; end
        if (acc && port == PORT_HIGH) begin m_high = val; m_hv = 1'b1; end
        if (acc && port == PORT_LOW)  begin m_low  = val; m_lv = 1'b1; end
        m_err = acc && (pair >= 3);
        #1;
        check_state(tag);
    endtask

    initial begin
        notReset = 1'b0;
        notHiReg = 24'h335AED; notLoReg = 24'h0077CB;
        req_valid = 1'b0; req_port = PORT_HIGH; req_pair = 2'd0; req_mode = 2'd0; take = 1'b0;
        req_valid16 = 1'b0; notHi16 = '1; notLo16 = '1;
        model_reset();
        repeat (3) @(negedge clk);
        notReset = 1'b1;

        // Reset state
        req_valid = 1'b1;
        #1;
        check_state("reset");
        check("reset.req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Directed scenarios
        step("pair0_high", 1'b1, PORT_HIGH, PAIR_BC, 3, 1'b0);
        check("pair0_high.value", 32'(High), 32'h1234);
        step("high_full_block", 1'b1, PORT_HIGH, PAIR_DE, 1, 1'b0);
        step("low_lo_byte", 1'b1, PORT_LOW, PAIR_HL, 2, 1'b0);
        check("low_lo_byte.value", 32'(Low), 32'h00FF);
        step("take_and_load", 1'b1, PORT_HIGH, PAIR_DE, 1, 1'b1);
        check("take_and_load.value", 32'(High), 32'h00A5);
        step("take_ignored", 1'b0, PORT_HIGH, PAIR_BC, 0, 1'b1);
        step("bad_pair", 1'b1, PORT_LOW, 3, 3, 1'b0);
        check("bad_pair.sel_err", 32'(sel_err), 32'd1);
        notHiReg = 24'hFFFFFF; notLoReg = 24'h000000;
        step("err_clears", 1'b0, PORT_LOW, PAIR_BC, 0, 1'b0);
        check("err_clears.sel_err", 32'(sel_err), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 300; i++) begin
            notHiReg = 24'($urandom);
            notLoReg = 24'($urandom);
            step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)));
        end

        // Fill both ports, then reset mid-cycle
        step("fill_high", 1'b1, PORT_HIGH, PAIR_BC, 3, 1'b0);
        step("fill_low", 1'b1, PORT_LOW, PAIR_HL, 3, 1'b0);
        @(negedge clk);
        req_valid = 1'b0; take = 1'b0;
        #2;
        notReset = 1'b0;
        model_reset();
        #1;
        check_state("mid_reset");
        @(negedge clk);
        notReset = 1'b1;

        // Wide build: 32-bit operand from pair 0
        @(negedge clk);
        notHi16 = 48'hFFFF_FFFF_EDCB; notLo16 = 48'hFFFF_FFFF_A987;
        req_port = PORT_HIGH; req_pair = 2'd0; req_mode = 2'd3; take = 1'b0;
        req_valid16 = 1'b1;
        #1;
        check("w16.req_ready", 32'(req_ready16), 32'd1);
        @(posedge clk);
        #1;
        req_valid16 = 1'b0;
        check("w16.High", High16, 32'h12345678);
        check("w16.High_valid", 32'(hv16), 32'd1);
        check("w16.Low_valid", 32'(lv16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
